// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I fields into instruction words and writes them sequentially into instruction memory
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            class_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [31:0]           imm_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [31:0]           wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  err_o
);
  typedef enum logic {LOAD, FULL} state_t;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  state_t                state_q;
  logic                  we_q, err_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  accept, legal;
  assign ready_o = state_q == LOAD;
  assign full_o  = state_q == FULL;
  assign legal   = class_i <= 4'd8;
  assign accept  = valid_i & ready_o & ~clear_i;
  assign count_d = count_q + (ADDR_WIDTH+1)'(1);
  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign count_o = count_q;
  assign err_o   = err_q;
  // Immediate bit scattering mirrors the decoder's reassembly so words round-trip unchanged
  always_comb begin
    wdata_d = '0;
    case (class_i)
      4'd0: wdata_d = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      4'd1: wdata_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
      4'd2: wdata_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
      4'd3: wdata_d = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
      4'd4: wdata_d = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], 7'b1100011};
      4'd5: wdata_d = {imm_i[31:12], rd_i, 7'b0010111};
      4'd6: wdata_d = {imm_i[31:12], rd_i, 7'b0110111};
      4'd7: wdata_d = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
      4'd8: wdata_d = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
      default: wdata_d = '0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      we_q <= accept & legal;
      if (clear_i) begin
        state_q <= LOAD;
        err_q   <= 1'b0;
        count_q <= '0;
      end else if (accept && legal) begin
        waddr_q <= count_q[ADDR_WIDTH-1:0];
        wdata_q <= wdata_d;
        count_q <= count_d;
        if (count_d == DEPTH_C) state_q <= FULL;
      end else if (accept) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule
